// File: rtl/uart_cmd_pkg.sv
//----------------------------------------------------------------------------
// Module   : uart_cmd_pkg
// Brief    : Shared types and constants for the UART command sequencer.
//            Optional macro UART_CMD_CKSUM_EN adds the checksum state.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package uart_cmd_pkg;

  // Default frame start marker
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_ADDR  = 3'd1,
    S_DHI   = 3'd2,
    S_DLO   = 3'd3,
`ifdef UART_CMD_CKSUM_EN
    S_CKSUM = 3'd4,
`endif
    S_ISSUE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_ADDR    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_CKSUM   = 2'd3
  } err_code_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] wdata;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/uart_cmd_ctrl_timeout.sv
//----------------------------------------------------------------------------
// Module   : uart_cmd_timeout
// Brief    : Inter-byte timeout counter with clear/enable and an expire flag
//            raised in the last counted cycle (count == LIMIT-1).
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module uart_cmd_timeout #(
  parameter int LIMIT = 17360,
  parameter int W     = $clog2(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expire = en && (cnt_q == LAST);

  // Next count: clear wins, a firing timeout also restarts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
//----------------------------------------------------------------------------
// Module   : uart_cmd_ctrl
// Brief    : Assembles SYNC/ADDR/DATA_HI/DATA_LO[/CKSUM] byte frames from a
//            UART receiver into register-write commands on a valid/ready
//            port; rejects bad address, timed-out, overrun and (optionally)
//            bad-checksum frames with a one-cycle error pulse.
//            Optional macro: UART_CMD_CKSUM_EN (adds trailing XOR checksum).
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES);

  state_t    state_q,     state_d;
  cmd_t      cmd_q,       cmd_d;
  logic      cmd_valid_q, cmd_valid_d;
  logic      frame_err_q, frame_err_d;
  err_code_t err_code_q,  err_code_d;
`ifdef UART_CMD_CKSUM_EN
  logic [7:0] cksum_q, cksum_d;
`endif

  logic to_en;
  logic to_expire;

  // Timer runs only while a frame is partially received
  assign to_en = (state_q != S_SYNC) && (state_q != S_ISSUE);

  uart_cmd_timeout #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_dv || !to_en),
    .en     (to_en),
    .expire (to_expire)
  );

  // Frame parser: a received byte always takes precedence over a timeout
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
`ifdef UART_CMD_CKSUM_EN
    cksum_d     = cksum_q;
`endif
    case (state_q)
      S_SYNC: begin
        if (rx_dv && (rx_byte == SYNC_BYTE)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (rx_dv) begin
          if (rx_byte[7]) begin
            cmd_d.addr = rx_byte[6:0];
`ifdef UART_CMD_CKSUM_EN
            cksum_d    = rx_byte;
`endif
            state_d    = S_DHI;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_ADDR;
            state_d     = S_SYNC;
          end
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_SYNC;
        end
      end
      S_DHI: begin
        if (rx_dv) begin
          cmd_d.wdata[15:8] = rx_byte;
`ifdef UART_CMD_CKSUM_EN
          cksum_d           = cksum_q ^ rx_byte;
`endif
          state_d           = S_DLO;
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_SYNC;
        end
      end
      S_DLO: begin
        if (rx_dv) begin
          cmd_d.wdata[7:0] = rx_byte;
`ifdef UART_CMD_CKSUM_EN
          cksum_d          = cksum_q ^ rx_byte;
          state_d          = S_CKSUM;
`else
          state_d          = S_ISSUE;
`endif
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_SYNC;
        end
      end
`ifdef UART_CMD_CKSUM_EN
      S_CKSUM: begin
        if (rx_dv) begin
          if (rx_byte == cksum_q) begin
            state_d = S_ISSUE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CKSUM;
            state_d     = S_SYNC;
          end
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_SYNC;
        end
      end
`endif
      S_ISSUE: begin
        // Bytes are dropped while a command is pending; only flag it
        // when the command is not leaving this very cycle
        if (cmd_ready) begin
          state_d = S_SYNC;
        end else if (rx_dv) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
      end
      default: state_d = S_SYNC;
    endcase
    cmd_valid_d = (state_d == S_ISSUE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_ADDR;
`ifdef UART_CMD_CKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
`ifdef UART_CMD_CKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_q.addr;
  assign cmd_wdata = cmd_q.wdata;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
//----------------------------------------------------------------------------
// Module   : tb_uart_cmd_ctrl
// Brief    : Directed self-checking bench for uart_cmd_ctrl
//            (short timeout: 4 clocks/bit x 5 bits = 20 cycles).
//            Honours UART_CMD_CKSUM_EN when defined.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_ctrl;

  localparam int TO_CYCLES = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        frame_err;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  // Event counters gathered mid-cycle
  int          n_cmd = 0;
  int          n_err = 0;
  logic [6:0]  last_addr = '0;
  logic [15:0] last_wdata = '0;
  logic [1:0]  last_err = '0;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .CLKS_PER_BIT (4),
    .TIMEOUT_BITS (5),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  // Record handshakes and error pulses
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      n_cmd      = n_cmd + 1;
      last_addr  = cmd_addr;
      last_wdata = cmd_wdata;
    end
    if (frame_err) begin
      n_err    = n_err + 1;
      last_err = err_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle rx_dv strobe; returns 1ns after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
    send_byte(8'hA5); idle(3);
    send_byte(a);     idle(3);
    send_byte(h);     idle(3);
    send_byte(l);
`ifdef UART_CMD_CKSUM_EN
    idle(3);
    send_byte(a ^ h ^ l);
`endif
  endtask

  initial begin
    // Reset values
    idle(3);
    check("rst_valid", 32'(cmd_valid), 32'h0);
    check("rst_addr",  32'(cmd_addr),  32'h0);
    check("rst_wdata", 32'(cmd_wdata), 32'h0);
    check("rst_err",   32'(frame_err), 32'h0);
    check("rst_code",  32'(err_code),  32'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame; cmd_valid one cycle after the last byte strobe
    send_frame(8'h81, 8'h12, 8'h34);
    check("f1_valid", 32'(cmd_valid), 32'h1);
    check("f1_addr",  32'(cmd_addr),  32'h01);
    check("f1_wdata", 32'(cmd_wdata), 32'h1234);
    idle(3);
    check("f1_ncmd",   32'(n_cmd),     32'd1);
    check("f1_nerr",   32'(n_err),     32'd0);
    check("f1_vdrop",  32'(cmd_valid), 32'h0);

    // Noise before SYNC is ignored silently
    send_byte(8'h00); idle(2);
    send_byte(8'hFF); idle(2);
    send_frame(8'h85, 8'hBE, 8'hEF);
    idle(3);
    check("f2_ncmd",  32'(n_cmd),      32'd2);
    check("f2_addr",  32'(last_addr),  32'h05);
    check("f2_wdata", 32'(last_wdata), 32'hBEEF);
    check("f2_nerr",  32'(n_err),      32'd0);

    // Read-flag address rejected, next frame still accepted
    send_byte(8'hA5); idle(3);
    send_byte(8'h01);
    check("addr_pulse", 32'(frame_err), 32'h1);
    check("addr_code",  32'(err_code),  32'h0);
    idle(3);
    check("addr_nerr", 32'(n_err), 32'd1);
    send_frame(8'h81, 8'hAB, 8'hCD);
    idle(3);
    check("addr_ncmd",  32'(n_cmd),      32'd3);
    check("addr_wdata", 32'(last_wdata), 32'hABCD);

    // Timeout: pulse exactly TO_CYCLES edges after the ADDR strobe edge
    send_byte(8'hA5); idle(3);
    send_byte(8'h81);
    idle(TO_CYCLES - 1);
    check("to_early", 32'(frame_err), 32'h0);
    idle(1);
    check("to_pulse", 32'(frame_err), 32'h1);
    check("to_code",  32'(err_code),  32'h1);
    idle(1);
    check("to_once", 32'(frame_err), 32'h0);
    send_byte(8'h12); idle(3);
    send_byte(8'h34); idle(3);
    check("to_ncmd", 32'(n_cmd), 32'd3);
    check("to_nerr", 32'(n_err), 32'd2);

    // Overrun while the consumer stalls
    cmd_ready = 1'b0;
    send_frame(8'h83, 8'h55, 8'hAA);
    check("ov_valid", 32'(cmd_valid), 32'h1);
    idle(10);
    send_byte(8'h77);
    check("ov_pulse", 32'(frame_err), 32'h1);
    check("ov_code",  32'(err_code),  32'h2);
    idle(38);
    check("ov_hold",  32'(cmd_valid), 32'h1);
    check("ov_addr",  32'(cmd_addr),  32'h03);
    check("ov_wdata", 32'(cmd_wdata), 32'h55AA);
    check("ov_ncmd0", 32'(n_cmd),     32'd3);
    cmd_ready = 1'b1;
    idle(3);
    check("ov_ncmd",  32'(n_cmd),      32'd4);
    check("ov_wd2",   32'(last_wdata), 32'h55AA);
    check("ov_vdrop", 32'(cmd_valid),  32'h0);
    check("ov_nerr",  32'(n_err),      32'd3);

`ifdef UART_CMD_CKSUM_EN
    // Wrong checksum rejected
    send_byte(8'hA5); idle(3);
    send_byte(8'h81); idle(3);
    send_byte(8'h12); idle(3);
    send_byte(8'h34); idle(3);
    send_byte(8'h00);
    check("ck_pulse", 32'(frame_err), 32'h1);
    check("ck_code",  32'(err_code),  32'h3);
    idle(3);
    check("ck_ncmd", 32'(n_cmd), 32'd4);
    n_err = n_err - 1;
`endif

    // Asynchronous reset mid-frame clears outputs at once
    send_byte(8'hA5); idle(3);
    send_byte(8'h82); idle(3);
    send_byte(8'h99);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_addr",  32'(cmd_addr),  32'h0);
    check("mr_wdata", 32'(cmd_wdata), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_byte(8'h11); idle(5);
    check("mr_ncmd",  32'(n_cmd),     32'd4);
    check("mr_valid", 32'(cmd_valid), 32'h0);
    check("mr_nerr",  32'(n_err),     32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
